booth_mul_arbiter: RTL and testbench

//  Shares one signed Booth multiplier datapath (CU-sequenced, WIDTH x WIDTH -> 2*WIDTH) between two

---
 rtl/booth_mul_arbiter.sv | 114 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin share of one signed multiplier between two valid/ready requesters
module booth_mul_arbiter #(
    parameter int WIDTH   = 3,
    parameter int PWIDTH  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    input  logic              mul_done,
    input  logic [PWIDTH-1:0] mul_product,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [PWIDTH-1:0] rsp_product,
    output logic              rsp_err,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [PWIDTH-1:0] prod_q, prod_d;
    logic              err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              g0, g1, rsp_hs;
    // Readies are gated by reset so every output reads 0 while rst is low.
    always_comb begin
        g0 = rst && state_q == IDLE && req0_valid && (!req1_valid || last_grant_q);
        g1 = rst && state_q == IDLE && req1_valid && !g0;
        rsp_hs = state_q == RESP && (grant_q ? rsp1_ready : rsp0_ready);
        state_d = state_q;
        grant_d = grant_q;
        last_grant_d = last_grant_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        prod_d = prod_q;
        err_d = err_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: if (g0 || g1) begin
                grant_d = g1;
                mul_a_d = g1 ? req1_a : req0_a;
                mul_b_d = g1 ? req1_b : req0_b;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mul_done) begin
                    prod_d = mul_product;
                    err_d = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    prod_d = '0;
                    err_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_hs) begin
                last_grant_d = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_grant_q <= 1'b1;
            mul_a_q <= '0;
            mul_b_q <= '0;
            prod_q <= '0;
            err_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_grant_q <= last_grant_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            prod_q <= prod_d;
            err_q <= err_d;
            timer_q <= timer_d;
        end
    end
    assign req0_ready  = g0;
    assign req1_ready  = g1;
    assign mul_start   = state_q == LAUNCH;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp0_valid  = state_q == RESP && !grant_q;
    assign rsp1_valid  = state_q == RESP && grant_q;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: scoreboarded random/directed bench with a behavioural multiplier and arbiter model
module tb_booth_mul_arbiter;
    localparam int W = 3;
    localparam int P = 6;
    localparam int TO = 15;
    logic clk = 0, rst = 0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic mul_start, mul_done;
    logic [W-1:0] mul_a, mul_b;
    logic [P-1:0] mul_product, rsp_product;
    logic rsp0_valid, rsp1_valid, rsp0_ready = 1, rsp1_ready = 1, rsp_err, busy;

    booth_mul_arbiter #(.WIDTH(W), .PWIDTH(P), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit port;
        logic [P-1:0] prod;
        bit err;
        int cyc;
        bit seen;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, pops = 0, starts = 0, acc_cyc = 0;
    int delay_cfg = 2, cur_delay = 0;
    bit inflight = 0, last_tb = 1, rsp_auto = 0, auto_req = 0;
    bit acc[2];
    logic [W-1:0] exp_a = 0, exp_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [P-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        return P'(ia * ib);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {req0_ready, req1_ready, mul_start, mul_a, mul_b, rsp0_valid, rsp1_valid,
                   rsp_product, rsp_err, busy}, 0);
    endtask

    // Multiplier model: done pulse cur_delay cycles after the start cycle, never if delay is large.
    initial begin
        int cnt;
        logic [W-1:0] ma, mb;
        cnt = 0; ma = 0; mb = 0;
        mul_done = 0;
        mul_product = 0;
        forever begin
            @(negedge clk);
            if (rst && mul_start) begin
                cnt = cur_delay;
                ma = mul_a;
                mb = mul_b;
            end
            @(posedge clk);
            #1;
            if (cnt > 0) begin
                cnt--;
                mul_done = cnt == 0;
            end else mul_done = 0;
            mul_product = mul_done ? smul(ma, mb) : P'($urandom);
        end
    end

    // Monitor and scoreboard: round-robin grant model, request capture, response comparison.
    initial begin
        bit want0, want1, n;
        int d;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
                inflight = 0;
                last_tb = 1;
                starts = 0;
                continue;
            end
            want0 = req0_valid && (!req1_valid || last_tb) && !inflight;
            want1 = req1_valid && !want0 && !inflight;
            chk("req0_ready", req0_ready, want0);
            chk("req1_ready", req1_ready, want1);
            chk("busy", busy, inflight);
            if (mul_start) begin
                starts++;
                chk("mul_start_cycle", cyc, acc_cyc + 1);
                chk("mul_a", mul_a, exp_a);
                chk("mul_b", mul_b, exp_b);
            end
            if (rsp0_valid || rsp1_valid) begin
                if (q.size() == 0) chk("rsp_valid_unexpected", {rsp1_valid, rsp0_valid}, 0);
                else begin
                    chk("rsp_both_valid", rsp0_valid && rsp1_valid, 0);
                    chk("rsp_port", rsp1_valid, q[0].port);
                    chk("rsp_product", rsp_product, q[0].prod);
                    chk("rsp_err", rsp_err, q[0].err);
                    if (!q[0].seen) begin
                        chk("rsp_latency", cyc, q[0].cyc);
                        q[0].seen = 1;
                    end
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        chk("mul_start_count", starts, 1);
                        starts = 0;
                        last_tb = q[0].port;
                        inflight = 0;
                        pops++;
                        void'(q.pop_front());
                    end
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                n = req1_valid && req1_ready;
                d = delay_cfg;
                if (d < 0) begin
                    d = $urandom_range(0, 17);
                    if (d == 0) d = 99;
                end
                cur_delay = d;
                exp_a = n ? req1_a : req0_a;
                exp_b = n ? req1_b : req0_b;
                e.port = n;
                e.err = !(d >= 1 && d <= TO);
                e.prod = e.err ? '0 : smul(exp_a, exp_b);
                e.cyc = cyc + 2 + (e.err ? TO : d);
                e.seen = 0;
                q.push_back(e);
                inflight = 1;
                acc[n] = 1;
                acc_cyc = cyc;
                starts = 0;
            end
        end
    end

    // Random requesters and response backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_req) begin
            if (!req0_valid || acc[0]) begin
                acc[0] = 0;
                req0_valid = $urandom_range(0, 3) != 0;
                req0_a = W'($urandom);
                req0_b = W'($urandom);
            end
            if (!req1_valid || acc[1]) begin
                acc[1] = 0;
                req1_valid = $urandom_range(0, 3) != 0;
                req1_a = W'($urandom);
                req1_b = W'($urandom);
            end
        end
        if (rsp_auto) begin
            rsp0_ready = $urandom_range(0, 2) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 0;
        req0_valid = 1;
        req1_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        rst = 1;
    endtask

    task automatic send(input bit n, input logic [W-1:0] a, input logic [W-1:0] b);
        acc[n] = 0;
        if (n) begin req1_a = a; req1_b = b; req1_valid = 1; end
        else begin req0_a = a; req0_b = b; req0_valid = 1; end
        for (int i = 0; i < 100 && !acc[n]; i++) @(posedge clk);
        chk("send_accept", acc[n], 1);
        #1;
        if (n) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (inflight || q.size() != 0); i++) @(posedge clk);
        chk("drain_inflight", inflight, 0);
        #1;
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int p0;
        do_reset();
        delay_cfg = 2;
        send(0, 3'b011, 3'b110);
        drain();
        delay_cfg = 99;
        send(1, 3'b011, 3'b011);
        drain();
        delay_cfg = 3;
        send(0, 3'b100, 3'b100);
        drain();
        delay_cfg = 15;
        send(1, 3'b111, 3'b101);
        drain();
        delay_cfg = 16;
        send(0, 3'b010, 3'b011);
        drain();
        delay_cfg = 1;
        send(1, 3'b101, 3'b011);
        drain();
        do_reset();
        delay_cfg = 1;
        p0 = pops;
        req0_a = 3'd1; req0_b = 3'd1; req1_a = 3'd2; req1_b = 3'd1;
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 200 && pops < p0 + 4; i++) @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        chk("alternate_pops", pops, p0 + 4);
        drain();
        delay_cfg = 2;
        rsp0_ready = 0;
        send(0, 3'b011, 3'b011);
        acc[1] = 0;
        req1_a = 3'b110; req1_b = 3'b010; req1_valid = 1;
        for (int i = 0; i < 50 && !rsp0_valid; i++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_rsp0_valid", rsp0_valid, 1);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1;
        for (int i = 0; i < 50 && !acc[1]; i++) @(posedge clk);
        #1;
        req1_valid = 0;
        drain();
        delay_cfg = 10;
        send(0, 3'b011, 3'b010);
        for (int i = 0; i < 20 && !mul_start; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk_zero("reset_mid_wait");
        repeat (15) begin
            @(negedge clk);
            chk("late_done_ignored", {busy, rsp0_valid, rsp1_valid}, 0);
        end
        @(posedge clk);
        #1;
        delay_cfg = 4;
        send(1, 3'b101, 3'b110);
        drain();
        delay_cfg = -1;
        rsp_auto = 1;
        auto_req = 1;
        repeat (1500) @(posedge clk);
        auto_req = 0;
        for (int i = 0; i < 300 && (req0_valid || req1_valid); i++) begin
            @(posedge clk);
            #1;
            if (acc[0]) req0_valid = 0;
            if (acc[1]) req1_valid = 0;
        end
        rsp_auto = 0;
        rsp0_ready = 1;
        rsp1_ready = 1;
        drain();
        chk("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
